// File: rtl/key_loader_pkg.sv
// key_loader_pkg: shared key geometry, header pattern and loader states
package key_loader_pkg;
    localparam int DEF_KEY_W = 41;
    localparam logic [7:0] DEF_HDR = 8'hA5;
    localparam int KEY_XOR_W = 37;
    localparam int KEY_MUX_W = 4;
    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_KEY, ST_PAR, ST_COMMIT, ST_ERR} state_t;
endpackage

// File: rtl/key_loader.sv
// key_loader: receives a serial header/key/parity frame and commits a verified key
module key_loader
    import key_loader_pkg::*;
#(
    parameter int KEY_W = DEF_KEY_W,
    parameter logic [7:0] HDR = DEF_HDR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ser_valid,
    input  logic             ser_data,
    output logic             ser_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);
    state_t state, nxt;
    logic [5:0] cnt;
    logic [KEY_W-1:0] shadow;
    logic par, acc, hdr_bad, last_key, good, launch;

    assign ser_ready = state inside {ST_HDR, ST_KEY, ST_PAR};
    assign busy = state inside {ST_HDR, ST_KEY, ST_PAR, ST_COMMIT};
    assign done = state == ST_COMMIT;
    assign acc = ser_valid & ser_ready;
    assign hdr_bad = ser_data != HDR[3'd7 - cnt[2:0]];
    assign last_key = cnt == 6'(KEY_W - 1);
    assign good = ~(par ^ ser_data);
    assign launch = start & (state inside {ST_IDLE, ST_ERR});

    // next-state decode; only accepted bits advance the frame
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE, ST_ERR: nxt = start ? ST_HDR : state;
            ST_HDR:    nxt = !acc ? ST_HDR : hdr_bad ? ST_ERR : (cnt == 6'd7) ? ST_KEY : ST_HDR;
            ST_KEY:    nxt = (acc && last_key) ? ST_PAR : ST_KEY;
            ST_PAR:    nxt = !acc ? ST_PAR : good ? ST_COMMIT : ST_ERR;
            ST_COMMIT: nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
    end

    // state, counter, shadow shifter and committed key; key only changes on a good parity bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shadow    <= '0;
            par       <= 1'b0;
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= nxt;
            if (launch) begin
                cnt    <= '0;
                shadow <= '0;
                par    <= 1'b0;
                err    <= 1'b0;
            end else if (acc) begin
                if (state == ST_HDR) begin
                    cnt <= (cnt == 6'd7) ? 6'd0 : cnt + 6'd1;
                    err <= hdr_bad;
                end
                if (state == ST_KEY) begin
                    shadow <= {ser_data, shadow[KEY_W-1:1]};
                    par    <= par ^ ser_data;
                    cnt    <= last_key ? 6'd0 : cnt + 6'd1;
                end
                if (state == ST_PAR) begin
                    err <= ~good;
                    if (good) begin
                        key_out   <= shadow;
                        key_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 Parameter KEY_W, default 41, is the key width: 37 XOR key bits (bits 0..36) followed by 4 mux-select bits (bits 37..40).
REQ-002 Parameter HDR, default 8'hA5, is the frame header pattern.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to begin a key load.
REQ-007 ser_valid  input  1  serial bit present on ser_data.
REQ-008 ser_data  input  1  serial key-frame bit.
REQ-009 ser_ready  output  1  loader accepts a bit this cycle.
REQ-010 key_out  output  KEY_W  committed key driven to the locked netlist's key inputs.
REQ-011 key_valid  output  1  key_out holds a verified key.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  one-cycle pulse on successful commit.
REQ-014 err  output  1  sticky failure flag for the last load attempt.

Function
REQ-015 States: IDLE, HDR, KEY, PAR, COMMIT, ERR.
REQ-016 A bit transfers only in a cycle where ser_valid and ser_ready are both 1; a cycle with ser_valid=0 is a stall and changes nothing.
REQ-017 ser_ready is 1 exactly in HDR, KEY and PAR; busy is 1 in HDR, KEY, PAR and COMMIT.
REQ-018 IDLE or ERR with start=1 goes to HDR on the next edge, clears err, and zeroes the bit counter, the shadow register and the parity accumulator.
REQ-019 start in any other state is ignored.
REQ-020 HDR receives 8 bits MSB first and compares each accepted bit against HDR immediately; the first mismatch goes to ERR.
REQ-021 After 8 matching bits, HDR goes to KEY.
REQ-022 KEY shifts KEY_W bits into a shadow register, bit 0 first, and XOR-accumulates parity over them; after bit KEY_W-1 the state goes to PAR.
REQ-023 PAR accepts one bit; the frame is good when accumulated parity XOR that bit = 0 (even parity over key plus parity bit).
REQ-024 A good frame goes to COMMIT; a bad frame goes to ERR.
REQ-025 COMMIT lasts one cycle: key_out <= shadow register, key_valid <= 1, done = 1; the next state is IDLE.
REQ-026 Latency from acceptance of the parity bit to key_out update is exactly one edge (2 edges to done deasserting).
REQ-027 ERR sets err = 1 and keeps it until the next accepted start.
REQ-028 On ERR, key_out and key_valid keep their previously committed values; a failed load never corrupts a good key.
REQ-029 During a load, key_out and key_valid hold the previous committed values; key_out never shows partial shadow contents.
REQ-030 The bit counter is 6 bits wide and counts 0..KEY_W-1 in KEY without wrap; the counter reaching terminal value and the state change happen on the same edge.

Reset
REQ-031 rst_n = 0 forces IDLE, key_out = 0, key_valid = 0, busy = 0, done = 0, err = 0, ser_ready = 0, shadow = 0, counter = 0, parity = 0, asynchronously.
REQ-032 rst_n asserted mid-frame discards the frame and the committed key; after release the block is in IDLE and needs a fresh start.
REQ-033 rst_n is released synchronously to clk by the system; the block contains no synchronizer.

Structure
REQ-034 A shared package key_loader_pkg holds KEY_W, HDR, the XOR/mux key field boundaries (37/4), and the state enumeration.
REQ-035 No sub-module; a single flat module of an FSM, a counter, a shadow shift register and an output register.

Verification
REQ-036 Good frame: start, then A5 followed by key 41'h0_1234_5678_9A and its correct parity bit, with ser_valid held high -> key_out = 41'h0_1234_5678_9A and key_valid = 1 one edge after the parity bit, done high for exactly 1 cycle, err = 0.
REQ-037 Bad header: start, then 8'hA4 -> ERR on the 8th bit, err = 1, key_out unchanged from the previous commit, key_valid unchanged.
REQ-038 Bad parity: a valid header and key 41'h1_FFFF_FFFF_FF with an inverted parity bit -> err = 1, previous key retained, done never pulses.
REQ-039 Stalls: the good frame with ser_valid toggled 1/0 on a random pattern (50% duty) -> same key_out as with no stalls, done 1 cycle after the last accepted bit.
REQ-040 Reset mid-KEY: rst_n low after 20 key bits -> all outputs 0 immediately, IDLE after release; start during a load is ignored and a subsequent full frame loads correctly.
